// File: rtl/muldiv_pkg.sv
// Shared ALU encodings plus the types used by the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1110;
    localparam logic [3:0] ALU_DIV  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } muldiv_op_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier or the restoring divider.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  muldiv_op_t       op,
    input  logic [XLEN-1:0]  acc_rem,
    input  logic [XLEN-1:0]  mcand_dvsr,
    input  logic [XLEN-1:0]  mplier_dvnd,
    output logic [XLEN-1:0]  acc_rem_next,
    output logic [XLEN-1:0]  mcand_dvsr_next,
    output logic [XLEN-1:0]  mplier_dvnd_next,
    output logic             q_bit
);

    logic [XLEN:0] rem_shift;

    // NOTE: every output gets a default first so no path through the branches can infer a latch.
    always_comb begin
        acc_rem_next     = acc_rem;
        mcand_dvsr_next  = mcand_dvsr;
        mplier_dvnd_next = mplier_dvnd;
        q_bit            = 1'b0;
        rem_shift        = {acc_rem, mplier_dvnd[XLEN-1]};

        if (op == OP_MUL) begin
            if (mplier_dvnd[0]) begin
                acc_rem_next = acc_rem + mcand_dvsr;
            end
            mcand_dvsr_next  = {mcand_dvsr[XLEN-2:0], 1'b0};
            mplier_dvnd_next = {1'b0, mplier_dvnd[XLEN-1:1]};
        end else begin
            // Remainder stays below the divisor, so the true difference always fits in XLEN bits.
            if (rem_shift >= {1'b0, mcand_dvsr}) begin
                acc_rem_next = rem_shift[XLEN-1:0] - mcand_dvsr;
                q_bit        = 1'b1;
            end else begin
                acc_rem_next = rem_shift[XLEN-1:0];
            end
            // Dividend bits leave at the top while quotient bits fill in from the bottom.
            mplier_dvnd_next = {mplier_dvnd[XLEN-2:0], q_bit};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multi-cycle MUL/DIV sequencer: stalls the pipeline for XLEN iterations, then presents a one-cycle result.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [XLEN-1:0]  result
);

    localparam int                CNT_W     = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t    state, state_next;
    muldiv_op_t       op_q, op_in;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  acc_rem, mcand_dvsr, mplier_dvnd;
    logic             neg_q;

    logic             accept, div_by_zero, div_overflow, div_special, last_step;
    logic [XLEN-1:0]  abs_a, abs_b, quotient, run_result, special_result;
    logic [XLEN-1:0]  step_acc_rem, step_mcand_dvsr, step_mplier_dvnd;
    logic             step_q_bit;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .op               (op_q),
        .acc_rem          (acc_rem),
        .mcand_dvsr       (mcand_dvsr),
        .mplier_dvnd      (mplier_dvnd),
        .acc_rem_next     (step_acc_rem),
        .mcand_dvsr_next  (step_mcand_dvsr),
        .mplier_dvnd_next (step_mplier_dvnd),
        .q_bit            (step_q_bit)
    );

    assign op_in          = (alu_op == ALU_DIV) ? OP_DIV : OP_MUL;
    assign accept         = start && is_muldiv(alu_op) && !flush;
    assign div_by_zero    = (operand_b == '0);
    assign div_overflow   = (operand_a == MOST_NEG) && (operand_b == '1);
    assign div_special    = (op_in == OP_DIV) && (div_by_zero || div_overflow);
    assign special_result = div_by_zero ? '1 : MOST_NEG;
    assign abs_a          = operand_a[XLEN-1] ? -operand_a : operand_a;
    assign abs_b          = operand_b[XLEN-1] ? -operand_b : operand_b;
    assign last_step      = (count == LAST_STEP);

    // The final quotient is the dividend register after this cycle's shift.
    assign quotient   = {mplier_dvnd[XLEN-2:0], step_q_bit};
    assign run_result = (op_q == OP_DIV) ? (neg_q ? -quotient : quotient) : step_acc_rem;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = div_special ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Gated by reset so an asynchronous abort drops the stall even while start is still held.
    assign stall = !reset && (((state == IDLE) && accept) || (state == RUN));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_MUL;
            count        <= '0;
            acc_rem      <= '0;
            mcand_dvsr   <= '0;
            mplier_dvnd  <= '0;
            neg_q        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != IDLE);
            result_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        count   <= '0;
                        acc_rem <= '0;
                        if (op_in == OP_DIV) begin
                            mcand_dvsr  <= abs_b;
                            mplier_dvnd <= abs_a;
                            neg_q       <= operand_a[XLEN-1] ^ operand_b[XLEN-1];
                        end else begin
                            mcand_dvsr  <= operand_a;
                            mplier_dvnd <= operand_b;
                            neg_q       <= 1'b0;
                        end
                        if (div_special) begin
                            result       <= special_result;
                            result_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_rem     <= step_acc_rem;
                    mcand_dvsr  <= step_mcand_dvsr;
                    mplier_dvnd <= step_mplier_dvnd;
                    count       <= count + 1'b1;
                    if (last_step && !flush) begin
                        result       <= run_result;
                        result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, signed division, special cases, flush and reset.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge: that cycle is cycle 0. Returns at the sampling point of cycle lat+1.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        start     = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            check({tag, " stall"}, {31'b0, stall}, 32'd1);
            check({tag, " early_valid"}, {31'b0, result_valid}, 32'd0);
            check({tag, " busy"}, {31'b0, busy}, (c > 0) ? 32'd1 : 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check({tag, " valid"}, {31'b0, result_valid}, 32'd1);
        check({tag, " result"}, result, exp);
        check({tag, " done_stall"}, {31'b0, stall}, 32'd0);
        check({tag, " done_busy"}, {31'b0, busy}, 32'd1);
        next_cycle();
        start  = 1'b0;
        alu_op = ALU_ADD;
        @(negedge clk);
        check({tag, " valid_drop"}, {31'b0, result_valid}, 32'd0);
        check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        alu_op    = ALU_ADD;
        operand_a = '0;
        operand_b = '0;
        flush     = 1'b0;

        @(negedge clk);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset valid", {31'b0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset state", {30'b0, dut.state}, {30'b0, IDLE});
        next_cycle();
        reset = 1'b0;

        next_cycle();
        run_op("mul_7x6", ALU_MUL, 32'd7, 32'd6, 33, 32'd42);

        next_cycle();
        run_op("mul_shift", ALU_MUL, 32'h1234_5678, 32'h10, 33, 32'h2345_6780);

        // Second DIV issued after one idle cycle, landing at cycle 68 of the pair.
        next_cycle();
        run_op("div_m20_3", ALU_DIV, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA);
        next_cycle();
        run_op("div_100_7", ALU_DIV, 32'd100, 32'd7, 33, 32'd14);

        next_cycle();
        run_op("div_100_m7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2);

        next_cycle();
        run_op("div_by_zero", ALU_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        next_cycle();
        run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);

        // Flush mid-RUN at cycle 10, then a fresh MUL at cycle 12.
        next_cycle();
        start     = 1'b1;
        alu_op    = ALU_MUL;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'hFFFF_FFFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("flush_run stall", {31'b0, stall}, 32'd1);
            next_cycle();
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle stall", {31'b0, stall}, 32'd1);
        next_cycle();
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flushed state", {30'b0, dut.state}, {30'b0, IDLE});
        check("flushed stall", {31'b0, stall}, 32'd0);
        check("flushed busy", {31'b0, busy}, 32'd0);
        check("flushed valid", {31'b0, result_valid}, 32'd0);
        next_cycle();
        run_op("mul_3x4", ALU_MUL, 32'd3, 32'd4, 33, 32'd12);

        // Flush with start in IDLE must not accept.
        next_cycle();
        start  = 1'b1;
        alu_op = ALU_MUL;
        flush  = 1'b1;
        @(negedge clk);
        check("flush_idle stall", {31'b0, stall}, 32'd0);
        next_cycle();
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle busy", {31'b0, busy}, 32'd0);
        check("flush_idle state", {30'b0, dut.state}, {30'b0, IDLE});

        // Flush in DONE leaves that cycle's result_valid intact.
        next_cycle();
        start     = 1'b1;
        alu_op    = ALU_DIV;
        operand_a = 32'd9;
        operand_b = 32'd0;
        @(negedge clk);
        check("flush_done start_stall", {31'b0, stall}, 32'd1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("flush_done valid", {31'b0, result_valid}, 32'd1);
        check("flush_done result", result, 32'hFFFF_FFFF);
        next_cycle();
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_done after_valid", {31'b0, result_valid}, 32'd0);
        check("flush_done after_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of cycle 5 of a MUL.
        next_cycle();
        start     = 1'b1;
        alu_op    = ALU_MUL;
        operand_a = 32'd9;
        operand_b = 32'd9;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
        end
        @(negedge clk);
        check("pre_reset stall", {31'b0, stall}, 32'd1);
        check("pre_reset busy", {31'b0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset stall", {31'b0, stall}, 32'd0);
        check("async_reset busy", {31'b0, busy}, 32'd0);
        check("async_reset valid", {31'b0, result_valid}, 32'd0);
        check("async_reset result", result, 32'd0);
        check("async_reset state", {30'b0, dut.state}, {30'b0, IDLE});
        start = 1'b0;
        next_cycle();
        reset = 1'b0;

        // Non-muldiv op never stalls.
        next_cycle();
        start  = 1'b1;
        alu_op = ALU_SUB;
        @(negedge clk);
        check("alu_sub stall", {31'b0, stall}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("alu_sub stall2", {31'b0, stall}, 32'd0);
        check("alu_sub busy", {31'b0, busy}, 32'd0);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the EX stage. When the control unit decodes an ALU op of MUL (4'b1110) or DIV (4'b1111), it holds the pipeline stalled and drives an iterative shift-add multiplier or restoring divider for XLEN cycles. It then presents the result to EX for one cycle. Every other ALU op passes through untouched; they never enter the sequencer.

## Interface
- XLEN, 32, operand and result width; must be ≥ 2.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  EX holds a valid instruction; held stable by the pipeline while stall=1.
- alu_op  in  4  ALU op from the control unit.
- operand_a  in  XLEN  rs1 value (multiplicand / dividend).
- operand_b  in  XLEN  rs2 value (multiplier / divisor).
- flush  in  1  kill the in-flight operation (branch/exception).
- stall  out  1  freeze IF/ID/EX; combinational.
- busy  out  1  registered; 1 in RUN or DONE.
- result_valid  out  1  result is on `result` this cycle.
- result  out  XLEN  MUL: low XLEN bits of the product. DIV: signed quotient.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept when start && alu_op ∈ {MUL, DIV}. At the edge, latch the operands and op, and load count=0.
  - DIV: latch the operand magnitudes plus neg_q = sign(a)^sign(b).
  - MUL: operands are treated as unsigned; the low XLEN bits are identical for signed operands.
  - Next state is RUN.
  - Special DIV cases skip RUN and go straight to DONE with a preset result:
    - operand_b==0 → all-ones.
    - operand_a==most-negative && operand_b==all-ones → most-negative.
- RUN, one iteration per cycle:
  - MUL: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - DIV: rem = {rem, dividend[MSB]}, dividend <<= 1. If rem ≥ divisor, rem -= divisor and shift in a quotient bit of 1; otherwise shift in 0.
  - count increments each cycle. When count==XLEN-1 the next state is DONE.
- DONE:
  - result_valid=1 and stall=0, so EX advances at this edge.
  - result = acc (MUL), or the quotient negated if neg_q (DIV).
  - Next state is always IDLE. start may still be high from the same instruction, but it is not re-accepted in DONE.
- Non-muldiv alu_op with start=1: stall=0, state stays IDLE.
- Reset values, held whenever reset=1:
  - state=IDLE, count=0, acc=0, result=0.
  - busy=0, result_valid=0, stall=0.

## Timing
- stall = (IDLE && start && is_muldiv && !flush) || RUN. It is 0 in DONE.
- Latency (cycle 0 = start seen in IDLE): RUN occupies cycles 1..XLEN, DONE is cycle XLEN+1, so result_valid appears XLEN+1 cycles after start.
- DIV special cases: DONE in cycle 1.
- stall is high for cycles 0..XLEN, which is XLEN+1 cycles.
- result and result_valid are registered. result holds its value after DONE until the next DONE; result_valid is high for exactly one cycle.
- flush:
  - In any state, the next state is IDLE and result_valid=0 in the following cycle.
  - flush in IDLE with start suppresses acceptance.
  - flush in DONE does not clear the already-asserted result_valid for that cycle.
- Reset mid-RUN aborts immediately and asynchronously: no result, stall drops at once.
- Back-to-back muldiv ops: DONE→IDLE→accept next, so one IDLE cycle separates them.

## Structure
- Shared package (alongside the control unit's encodings):
  - ALU_MUL=4'b1110 and ALU_DIV=4'b1111, plus the other alu_op constants.
  - muldiv_state_t enum {IDLE, RUN, DONE}.
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: op, acc/rem, multiplicand/divisor, multiplier/dividend.
  - Outputs: the next values and the quotient bit.
  - The sequencer owns the FSM, counter, sign fix-up and special cases.

## Test plan
- MUL 7×6, start at cycle 0 → stall=1 cycles 0..32, result_valid=1 with result=42 at cycle 33, stall=0 at cycle 33.
- DIV −20/3 (0xFFFFFFEC, 3) → result 0xFFFFFFFA (−6) at cycle 33. Then DIV 100/7 back-to-back → 14 at cycle 68.
- DIV 5/0 → result 0xFFFFFFFF at cycle 1, stall high only at cycle 0. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1.
- MUL 0xFFFFFFFF×0xFFFFFFFF, flush at cycle 10 → IDLE at cycle 11, no result_valid. A new MUL 3×4 at cycle 12 → 12 at cycle 45.
- reset pulsed mid-RUN at cycle 5 → stall, busy and result_valid are 0 asynchronously and the state is IDLE. alu_op=4'b0001 with start=1 → stall stays 0.
